// File: rtl/door_controller.sv
// Elevator door FSM: dwell/close timing, overload hold, and the
// weight counter clear pulse with its synchronizer blanking window.
module door_controller #(
    parameter int OPEN_CYCLES  = 8,
    parameter int CLOSE_CYCLES = 4,
    parameter int CLEAR_CYCLES = 3,
    parameter int RST_PULSE    = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arrive,
    input  logic open_btn,
    input  logic close_btn,
    input  logic weight_limit_exceeded,
    input  logic weight_ok_sense,
    output logic door,
    output logic weight_flip_reset,
    output logic overload_alarm,
    output logic depart_ok
);

    localparam int DW = $clog2(OPEN_CYCLES);
    localparam int CW = (CLOSE_CYCLES > 1) ? $clog2(CLOSE_CYCLES) : 1;
    localparam int PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
    localparam int BW = $clog2(RST_PULSE + 3);
    localparam int KW = $clog2(CLEAR_CYCLES + 1);

    localparam logic [DW-1:0] DWELL_LD = DW'(OPEN_CYCLES - 1);
    localparam logic [CW-1:0] CLOSE_LD = CW'(CLOSE_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LD = PW'(RST_PULSE - 1);
    localparam logic [BW-1:0] BLANK_LD = BW'(RST_PULSE + 2);
    localparam logic [KW-1:0] OK_LAST  = KW'(CLEAR_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        OPEN,
        CLOSING,
        READY,
        OVERLOAD
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [DW-1:0] dwell;
    logic [DW-1:0] dwell_n;
    logic [CW-1:0] ctmr;
    logic [CW-1:0] ctmr_n;
    logic [KW-1:0] ok_cnt;
    logic [KW-1:0] ok_cnt_n;
    logic [PW-1:0] pcnt;
    logic [BW-1:0] bcnt;
    logic          wl_m;
    logic          wl_s;
    logic          blank;
    logic          trip;
    logic          pulse_go;

    assign blank = (bcnt != '0);
    assign trip  = wl_s & ~blank;

    always_comb begin
        state_n  = state;
        dwell_n  = dwell;
        ctmr_n   = ctmr;
        ok_cnt_n = '0;
        pulse_go = 1'b0;
        unique case (state)
            IDLE: begin
                if (arrive | open_btn) begin
                    state_n = OPEN;
                    dwell_n = DWELL_LD;
                end
            end
            OPEN: begin
                // the dwell timer stays frozen while overloaded
                if (trip) begin
                    state_n = OVERLOAD;
                end else if (open_btn) begin
                    dwell_n = DWELL_LD;
                end else if (close_btn || dwell == '0) begin
                    state_n = CLOSING;
                    ctmr_n  = CLOSE_LD;
                end else begin
                    dwell_n = dwell - 1'b1;
                end
            end
            CLOSING: begin
                if (trip) begin
                    state_n = OVERLOAD;
                end else if (open_btn | arrive) begin
                    state_n = OPEN;
                    dwell_n = DWELL_LD;
                end else if (ctmr == '0) begin
                    state_n  = READY;
                    pulse_go = 1'b1;
                end else begin
                    ctmr_n = ctmr - 1'b1;
                end
            end
            READY: begin
                state_n = IDLE;
            end
            OVERLOAD: begin
                if (weight_ok_sense) begin
                    if (ok_cnt == OK_LAST) begin
                        state_n  = OPEN;
                        dwell_n  = DWELL_LD;
                        pulse_go = 1'b1;
                    end else begin
                        ok_cnt_n = ok_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            dwell          <= '0;
            ctmr           <= '0;
            ok_cnt         <= '0;
            wl_m           <= 1'b0;
            wl_s           <= 1'b0;
            door           <= 1'b0;
            overload_alarm <= 1'b0;
            depart_ok      <= 1'b0;
        end else begin
            state          <= state_n;
            dwell          <= dwell_n;
            ctmr           <= ctmr_n;
            ok_cnt         <= ok_cnt_n;
            wl_m           <= weight_limit_exceeded;
            wl_s           <= wl_m;
            door           <= (state_n == OPEN) || (state_n == OVERLOAD);
            overload_alarm <= (state_n == OVERLOAD);
            depart_ok      <= (state_n == READY);
        end
    end

    // a new request restarts both the pulse width and the blanking window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_flip_reset <= 1'b0;
            pcnt              <= '0;
            bcnt              <= '0;
        end else if (pulse_go) begin
            weight_flip_reset <= 1'b1;
            pcnt              <= PULSE_LD;
            bcnt              <= BLANK_LD;
        end else begin
            if (weight_flip_reset) begin
                if (pcnt == '0) begin
                    weight_flip_reset <= 1'b0;
                end else begin
                    pcnt <= pcnt - 1'b1;
                end
            end
            if (bcnt != '0) begin
                bcnt <= bcnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_door_controller.sv
// Table-driven bench for door_controller: per-cycle input/expected
// records fed through a scoreboard queue, plus a mid-pulse reset sequence.
module tb_door_controller;

    logic clk;
    logic rst_n;
    logic arrive;
    logic open_btn;
    logic close_btn;
    logic wl;
    logic ok;
    logic door;
    logic weight_flip_reset;
    logic overload_alarm;
    logic depart_ok;

    door_controller #(
        .OPEN_CYCLES (8),
        .CLOSE_CYCLES(4),
        .CLEAR_CYCLES(3),
        .RST_PULSE   (2)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .arrive               (arrive),
        .open_btn             (open_btn),
        .close_btn            (close_btn),
        .weight_limit_exceeded(wl),
        .weight_ok_sense      (ok),
        .door                 (door),
        .weight_flip_reset    (weight_flip_reset),
        .overload_alarm       (overload_alarm),
        .depart_ok            (depart_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inputs: {arrive, open_btn, close_btn, wl, ok}
    // expect: {door, weight_flip_reset, overload_alarm, depart_ok}
    typedef struct packed {
        logic [4:0] in;
        logic [3:0] exp;
    } vec_t;

    localparam logic [4:0] NON = 5'b00000;
    localparam logic [4:0] ARR = 5'b10000;
    localparam logic [4:0] OPN = 5'b01000;
    localparam logic [4:0] CLS = 5'b00100;
    localparam logic [4:0] WL  = 5'b00010;
    localparam logic [4:0] OK  = 5'b00001;

    vec_t       tbl[$];
    logic [3:0] exp_q[$];
    int         n_vec  = 0;
    int         n_fail = 0;
    int         n_chk  = 0;

    function automatic void add(input int n, input logic [4:0] in,
                                input logic [3:0] e);
        for (int i = 0; i < n; i++) tbl.push_back({in, e});
    endfunction

    task automatic drive(input logic [4:0] in, input logic [3:0] e);
        @(negedge clk);
        {arrive, open_btn, close_btn, wl, ok} = in;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        logic [3:0] e;
        logic [3:0] got;
        #1;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            got = {door, weight_flip_reset, overload_alarm, depart_ok};
            n_vec++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL vec%0d: got %b, required %b", n_chk, got, e);
            end
            n_chk++;
        end
    end

    task automatic check_zero(input string name);
        logic [3:0] got;
        got = {door, weight_flip_reset, overload_alarm, depart_ok};
        n_vec++;
        if (got !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s: got %b, required 0000", name, got);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {arrive, open_btn, close_btn, wl, ok} = NON;

        // normal cycle
        add(1, ARR, 4'b1000);
        add(7, NON, 4'b1000);
        add(4, NON, 4'b0000);
        add(1, NON, 4'b0101);
        add(1, NON, 4'b0100);
        add(2, NON, 4'b0000);
        // open_btn extends dwell, open+close keeps the door open
        add(1, ARR, 4'b1000);
        add(4, NON, 4'b1000);
        add(2, OPN, 4'b1000);
        add(3, NON, 4'b1000);
        add(1, OPN | CLS, 4'b1000);
        add(7, NON, 4'b1000);
        add(4, NON, 4'b0000);
        add(1, NON, 4'b0101);
        add(1, NON, 4'b0100);
        add(2, NON, 4'b0000);
        // close_btn shortens dwell, open_btn in READY ignored
        add(1, ARR, 4'b1000);
        add(1, NON, 4'b1000);
        add(1, CLS, 4'b0000);
        add(3, NON, 4'b0000);
        add(1, NON, 4'b0101);
        add(1, OPN, 4'b0100);
        add(2, NON, 4'b0000);
        // overload in OPEN, buttons ignored, 1,1,0,1,1,1 clear
        add(1, ARR, 4'b1000);
        add(2, NON, 4'b1000);
        add(2, WL, 4'b1000);
        add(1, WL, 4'b1010);
        add(1, WL | CLS, 4'b1010);
        add(1, WL | OPN, 4'b1010);
        add(1, WL | CLS, 4'b1010);
        add(1, WL, 4'b1010);
        add(2, WL | OK, 4'b1010);
        add(1, WL, 4'b1010);
        add(2, WL | OK, 4'b1010);
        add(1, WL | OK, 4'b1100);
        add(1, WL, 4'b1100);
        add(6, NON, 4'b1000);
        add(4, NON, 4'b0000);
        add(1, NON, 4'b0101);
        add(1, NON, 4'b0100);
        add(2, NON, 4'b0000);
        // reopen from CLOSING, overload from CLOSING, arrive in CLOSING
        add(1, ARR, 4'b1000);
        add(7, NON, 4'b1000);
        add(1, NON, 4'b0000);
        add(1, OPN, 4'b1000);
        add(7, NON, 4'b1000);
        add(1, NON, 4'b0000);
        add(2, WL, 4'b0000);
        add(1, WL, 4'b1010);
        add(2, WL | OK, 4'b1010);
        add(1, WL | OK, 4'b1100);
        add(1, WL, 4'b1100);
        add(6, NON, 4'b1000);
        add(1, NON, 4'b0000);
        add(1, ARR, 4'b1000);
        add(7, NON, 4'b1000);
        add(4, NON, 4'b0000);
        add(1, NON, 4'b0101);
        add(1, NON, 4'b0100);
        add(2, NON, 4'b0000);

        repeat (2) @(posedge clk);
        #1 check_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) drive(tbl[i].in, tbl[i].exp);

        // reset while depart_ok and the clear pulse are active
        drive(ARR, 4'b1000);
        repeat (7) drive(NON, 4'b1000);
        repeat (4) drive(NON, 4'b0000);
        drive(NON, 4'b0101);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) drive(NON, 4'b0000);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected vectors unchecked, required 0",
                     exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
